// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: shares one FPU between NB_CORES cores.
// Round-robin request arbitration with a grant lock while the FPU stalls,
// a credit counter capping issued-but-unanswered operations, and
// tag-based response routing back to the issuing core.
// Optional build macro: FPU_SHARE_ARB_RESP_REG_EN registers the response
// path (1-cycle latency); without it the response path is combinational.
`timescale 1ns/1ps
module fpu_share_arbiter #(
  parameter int NB_CORES        = 4,
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NB_CORES-1:0]                               core_req_i,
  output logic [NB_CORES-1:0]                               core_gnt_o,
  input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]  core_operands_i,
  input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]             core_op_i,
  input  logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0]           core_flags_i,
  output logic [NB_CORES-1:0]                               core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                             core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]                        core_rflags_o,
  output logic                                              fpu_req_o,
  output logic [ID_WIDTH-1:0]                               fpu_ID_o,
  output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]                fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                           fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]                         fpu_flags_o,
  input  logic                                              fpu_gnt_i,
  input  logic                                              fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                             fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]                        fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]                               fpu_rID_i,
  output logic [3:0]                                        outstanding_o
);

  localparam int IDXW = $clog2(NB_CORES);

  logic [IDXW-1:0]     rr_ptr;
  logic                lock_vld;
  logic [IDXW-1:0]     lock_idx;
  logic [IDXW-1:0]     winner;
  logic [IDXW-1:0]     cand;
  logic                found;
  int                  rr_idx;
  logic                hs;
  logic [NB_CORES-1:0] rsp_vld;

  // Winner select: a locked core that still requests keeps the slot,
  // otherwise search upward from rr_ptr with wrap-around.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    rr_idx = 0;
    if (lock_vld && core_req_i[lock_idx]) begin
      winner = lock_idx;
      found  = 1'b1;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        rr_idx = int'(rr_ptr) + i;
        if (rr_idx >= NB_CORES) rr_idx = rr_idx - NB_CORES;
        cand = IDXW'(rr_idx);
        if (!found && core_req_i[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  assign fpu_req_o      = found && (outstanding_o < 4'(MAX_OUTSTANDING));
  assign hs             = fpu_req_o && fpu_gnt_i;
  assign fpu_ID_o       = ID_WIDTH'(winner);
  assign fpu_operands_o = core_operands_i[winner];
  assign fpu_op_o       = core_op_i[winner];
  assign fpu_flags_o    = core_flags_i[winner];
  assign core_gnt_o     = hs ? (NB_CORES'(1) << winner) : '0;

  // Pointer moves past the winner only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rr_ptr <= '0;
    else if (hs) rr_ptr <= (int'(winner) == NB_CORES - 1) ? '0 : winner + 1'b1;
  end

  // Lock the current winner while the FPU stalls a pending request;
  // a dropped request simply falls back to round-robin next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else begin
      lock_vld <= fpu_req_o && !fpu_gnt_i;
      lock_idx <= winner;
    end
  end

  // Credit counter: issue adds, response subtracts, never below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          outstanding_o <= '0;
    else if (hs && !fpu_rvalid_i)                        outstanding_o <= outstanding_o + 4'd1;
    else if (!hs && fpu_rvalid_i && outstanding_o != 0)  outstanding_o <= outstanding_o - 4'd1;
  end

  // Per-core response decode; out-of-range tags match no core and drop.
  for (genvar c = 0; c < NB_CORES; c++) begin : g_rsp
    assign rsp_vld[c] = fpu_rvalid_i && (fpu_rID_i == ID_WIDTH'(c));
  end

`ifdef FPU_SHARE_ARB_RESP_REG_EN
  // Registered response path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid_o <= '0;
      core_rdata_o  <= '0;
      core_rflags_o <= '0;
    end else begin
      core_rvalid_o <= rsp_vld;
      core_rdata_o  <= fpu_rdata_i;
      core_rflags_o <= fpu_rflags_i;
    end
  end
`else
  // Combinational response path, forced to zero while in reset.
  always_comb begin
    core_rvalid_o = rst_n ? rsp_vld      : '0;
    core_rdata_o  = rst_n ? fpu_rdata_i  : '0;
    core_rflags_o = rst_n ? fpu_rflags_i : '0;
  end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed scenarios plus random traffic; expected
// grants, responses and per-cycle status are queued by a reference model
// and consumed by an independent monitor.
`timescale 1ns/1ps
module tb_fpu_share_arbiter;
  localparam int NB = 4;
  localparam int MAXO = 4;
`ifdef FPU_SHARE_ARB_RESP_REG_EN
  localparam int RSP_LAT = 1;
`else
  localparam int RSP_LAT = 0;
`endif

  logic clk, rst_n;
  logic [3:0] core_req_i, core_gnt_o, core_rvalid_o;
  logic [3:0][1:0][31:0] core_operands_i;
  logic [3:0][5:0] core_op_i;
  logic [3:0][14:0] core_flags_i;
  logic [31:0] core_rdata_o, fpu_rdata_i;
  logic [4:0] core_rflags_o, fpu_rflags_i;
  logic fpu_req_o, fpu_gnt_i, fpu_rvalid_i;
  logic [8:0] fpu_ID_o, fpu_rID_i;
  logic [1:0][31:0] fpu_operands_o;
  logic [5:0] fpu_op_o;
  logic [14:0] fpu_flags_o;
  logic [3:0] outstanding_o;

  fpu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
    .fpu_req_o(fpu_req_o), .fpu_ID_o(fpu_ID_o), .fpu_operands_o(fpu_operands_o),
    .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
    .fpu_rID_i(fpu_rID_i), .outstanding_o(outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic req; logic [3:0] cnt; int id; logic [3:0] gnt; } st_t;
  typedef struct { int id; logic [1:0][31:0] opnd; logic [5:0] op; logic [14:0] fl; } gx_t;
  typedef struct { logic [3:0] vec; logic [31:0] data; logic [4:0] fl; } rx_t;

  st_t st_q[$];
  gx_t gx_q[$];
  rx_t rx_q[$];
  int  gnt_log[$];

  int total = 0;
  int bad = 0;

  // reference model state
  int m_rr, m_cnt, m_lock_core;
  bit m_lock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0; m_lock = 0; m_lock_core = 0;
    st_q.delete(); gx_q.delete(); rx_q.delete();
  endtask

  // Predicts this cycle's behaviour from the currently driven inputs.
  task automatic model_step();
    st_t s; gx_t g; rx_t r;
    bit ok, hs;
    int w;
    ok = (core_req_i != 0) && (m_cnt < MAXO);
    w = -1;
    if (m_lock && core_req_i[m_lock_core]) w = m_lock_core;
    else
      for (int k = 0; k < NB; k++)
        if (w < 0 && core_req_i[(m_rr + k) % NB]) w = (m_rr + k) % NB;
    hs = ok && fpu_gnt_i;
    s.req = ok; s.cnt = 4'(m_cnt); s.id = w; s.gnt = hs ? (4'b1 << w) : 4'b0;
    st_q.push_back(s);
    if (hs) begin
      g.id = w; g.opnd = core_operands_i[w]; g.op = core_op_i[w]; g.fl = core_flags_i[w];
      gx_q.push_back(g);
    end
    if (fpu_rvalid_i && fpu_rID_i < NB) begin
      r.vec = 4'b1 << fpu_rID_i; r.data = fpu_rdata_i; r.fl = fpu_rflags_i;
      rx_q.push_back(r);
    end
    if (hs && !fpu_rvalid_i) m_cnt++;
    else if (!hs && fpu_rvalid_i && m_cnt > 0) m_cnt--;
    if (hs) m_rr = (w + 1) % NB;
    m_lock = ok && !fpu_gnt_i;
    m_lock_core = w;
  endtask

  // One clock cycle of stimulus, driven just after the rising edge.
  task automatic cyc(input logic [3:0] req, input logic gnt, input logic rv,
                     input logic [8:0] rid, input logic [31:0] rd);
    @(posedge clk); #1;
    core_req_i = req; fpu_gnt_i = gnt; fpu_rvalid_i = rv; fpu_rID_i = rid;
    fpu_rdata_i = rd; fpu_rflags_i = 5'($urandom);
    for (int c = 0; c < NB; c++) begin
      core_operands_i[c][0] = $urandom; core_operands_i[c][1] = $urandom;
      core_op_i[c] = 6'($urandom); core_flags_i[c] = 15'($urandom);
    end
    model_step();
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Monitor: per-cycle status plus grant/response transactions.
  always @(negedge clk) begin
    st_t s; gx_t g; rx_t r;
    if (rst_n) begin
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("fpu_req", fpu_req_o, s.req);
        chk("outstanding", outstanding_o, s.cnt);
        chk("gnt_vec", core_gnt_o, s.gnt);
        if (s.req) chk("fpu_id", fpu_ID_o, s.id);
      end
      if (core_gnt_o != 0) begin
        gnt_log.push_back(int'(fpu_ID_o));
        if (gx_q.size() == 0) chk("spurious_gnt", core_gnt_o, 0);
        else begin
          g = gx_q.pop_front();
          chk("gnt_id", fpu_ID_o, g.id);
          chk("gnt_opnd", fpu_operands_o, g.opnd);
          chk("gnt_op", fpu_op_o, g.op);
          chk("gnt_flags", fpu_flags_o, g.fl);
        end
      end
      if (core_rvalid_o != 0) begin
        if (rx_q.size() == 0) chk("spurious_rsp", core_rvalid_o, 0);
        else begin
          r = rx_q.pop_front();
          chk("rsp_vec", core_rvalid_o, r.vec);
          chk("rsp_data", core_rdata_o, r.data);
          chk("rsp_flags", core_rflags_o, r.fl);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp033[5];
    int base;
    exp033 = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    core_req_i = '0; fpu_gnt_i = 0; fpu_rvalid_i = 1'b1; fpu_rID_i = 9'd1;
    fpu_rdata_i = 32'hDEADBEEF; fpu_rflags_i = 5'h1F;
    core_operands_i = '0; core_op_i = '0; core_flags_i = '0;
    model_reset();
    #12;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_rdata", core_rdata_o, 0);
    chk("rst_rflags", core_rflags_o, 0);
    chk("rst_fpu_req", fpu_req_o, 0);
    fpu_rvalid_i = 0; fpu_rdata_i = 0; fpu_rflags_i = 0;
    @(posedge clk); #1; rst_n = 1'b1;

    // all cores requesting, FPU always ready; dropped responses keep count at 0
    base = gnt_log.size();
    repeat (5) cyc(4'hF, 1, 1, 9'd7, $urandom);
    settle();
    chk("rr_order_cnt", gnt_log.size() - base, 5);
    for (int k = 0; k < 5; k++)
      if (gnt_log.size() > base + k) chk("rr_order", gnt_log[base + k], exp033[k]);

    // lock: core 2 stalls while core 1 (now higher priority) joins
    base = gnt_log.size();
    cyc(4'b0100, 0, 0, 0, 0);
    cyc(4'b0110, 0, 0, 0, 0);
    cyc(4'b0110, 0, 0, 0, 0);
    cyc(4'b0110, 1, 0, 0, 0);
    settle();
    chk("lock_cnt", gnt_log.size() - base, 1);
    if (gnt_log.size() > base) chk("lock_winner", gnt_log[base], 2);

    // credit limit
    cyc(4'b0000, 0, 1, 9'd1, $urandom);
    repeat (4) cyc(4'b0001, 1, 0, 0, 0);
    cyc(4'b0001, 1, 0, 0, 0);
    chk("full_cnt", outstanding_o, 4);
    chk("full_block", fpu_req_o, 0);
    cyc(4'b0001, 1, 1, 9'd0, $urandom);
    cyc(4'b0001, 1, 0, 0, 0);
    chk("resume_cnt", outstanding_o, 3);
    chk("resume_req", fpu_req_o, 1);
    cyc(4'b0000, 0, 1, 9'd0, $urandom);
    cyc(4'b0000, 0, 1, 9'd2, $urandom);

    // simultaneous issue and response at count 2
    cyc(4'b0001, 1, 1, 9'd0, $urandom);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("simul_cnt", outstanding_o, 2);

    // routing and out-of-range drop
    cyc(4'b0000, 0, 1, 9'd3, 32'h3F800000);
    cyc(4'b0000, 0, 1, 9'd5, 32'h40000000);
    repeat (RSP_LAT + 1) cyc(4'b0000, 0, 0, 0, 0);
    chk("drop_cnt", outstanding_o, 0);

    // reset mid-operation at count 3
    repeat (3) cyc(4'b0001, 1, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    settle();
    chk("pre_rst_cnt", outstanding_o, 3);
    #1; rst_n = 1'b0; #1;
    chk("midrst_cnt", outstanding_o, 0);
    chk("midrst_rvalid", core_rvalid_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    base = gnt_log.size();
    cyc(4'b1010, 1, 0, 0, 0);
    settle();
    chk("post_rst_cnt", gnt_log.size() - base, 1);
    if (gnt_log.size() > base) chk("post_rst_winner", gnt_log[base], 1);

    // random traffic
    for (int n = 0; n < 400; n++)
      cyc(4'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0,
          9'($urandom_range(0, 7)), $urandom);
    repeat (3) cyc(4'b0000, 0, 0, 0, 0);
    settle();
    chk("drain_gnt_q", gx_q.size(), 0);
    chk("drain_rsp_q", rx_q.size(), 0);
    chk("drain_st_q", st_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_share_arbiter.md
FPU_SHARE_ARBITER -- requirements
Module: fpu_share_arbiter

Interface
REQ-001 SHALL have parameter NB_CORES, default 4: number of requesting cores; legal range 2..16.
REQ-002 SHALL have parameter ID_WIDTH, default 9: FPU tag width; must be >= clog2(NB_CORES).
REQ-003 SHALL have parameters NB_ARGS=2, DATA_WIDTH=32, OPCODE_WIDTH=6, FLAGS_IN_WIDTH=15 and FLAGS_OUT_WIDTH=5, each matching the shared FPU port.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of issued-but-unanswered operations; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port core_req_i, input, NB_CORES bits: per-core request.
REQ-008 SHALL have port core_gnt_o, output, NB_CORES bits: per-core grant.
REQ-009 SHALL have port core_operands_i, input, NB_CORES x NB_ARGS x DATA_WIDTH bits: operands.
REQ-010 SHALL have ports core_op_i (NB_CORES x OPCODE_WIDTH) and core_flags_i (NB_CORES x FLAGS_IN_WIDTH), inputs: opcode and flags.
REQ-011 SHALL have port core_rvalid_o, output, NB_CORES bits: per-core response valid.
REQ-012 SHALL have ports core_rdata_o (DATA_WIDTH) and core_rflags_o (FLAGS_OUT_WIDTH), outputs: response data and flags, broadcast to all cores.
REQ-013 SHALL have outputs fpu_req_o (1), fpu_ID_o (ID_WIDTH), fpu_operands_o (NB_ARGS x DATA_WIDTH), fpu_op_o and fpu_flags_o: the request to the FPU.
REQ-014 SHALL have input fpu_gnt_i (1): FPU ready.
REQ-015 SHALL have inputs fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i and fpu_rID_i: the FPU response.
REQ-016 SHALL have output outstanding_o, 4 bits: current credit count.

Function
REQ-017 SHALL assert fpu_req_o = (|core_req_i) & (outstanding_o < MAX_OUTSTANDING), combinationally.
REQ-018 SHALL select a winner round-robin, starting the search at rr_ptr and proceeding upward with wrap-around.
REQ-019 SHALL drive the fpu_* request fields from the winner, with fpu_ID_o = zero-extended winner index; 0-cycle request latency.
REQ-020 SHALL assert core_gnt_o[w] = fpu_req_o & fpu_gnt_i only for the winner w; all other grant bits 0.
REQ-021 SHALL lock the winner while fpu_req_o=1 & fpu_gnt_i=0, so the selection is unchanged on the next cycle even if a higher-priority core requests.
REQ-022 SHALL treat a dropped core_req_i from the locked core as releasing the lock on the next cycle.
REQ-023 SHALL set rr_ptr = (w+1) mod NB_CORES on a handshake (fpu_req_o & fpu_gnt_i) and hold it otherwise.
REQ-024 SHALL update outstanding_o as follows: +1 on a handshake; -1 on fpu_rvalid_i; unchanged when both occur in the same cycle.
REQ-025 SHALL block issue (fpu_req_o=0) while outstanding_o = MAX_OUTSTANDING, and SHALL never decrement below 0 (a response at count 0 leaves the count unchanged).
REQ-026 SHALL route a response as core_rvalid_o[fpu_rID_i] = fpu_rvalid_i, with data and flags passed through.
REQ-027 SHALL drop a response with fpu_rID_i >= NB_CORES (all core_rvalid_o = 0) while still decrementing outstanding_o.
REQ-028 SHALL have no response back-pressure: cores accept core_rvalid_o unconditionally.

Reset
REQ-029 SHALL set, on rst_n low: rr_ptr=0, lock cleared, outstanding_o=0, core_rvalid_o=0, core_rdata_o=0, core_rflags_o=0.
REQ-030 SHALL discard in-flight operations on reset mid-operation; no credits are restored afterwards.

Configuration
REQ-031 SHALL, with macro FPU_SHARE_ARB_RESP_REG_EN defined, register core_rvalid_o, core_rdata_o and core_rflags_o, giving 1-cycle response latency.
REQ-032 SHALL, without FPU_SHARE_ARB_RESP_REG_EN, make the response path combinational (0 cycles); the credit counter timing is identical in both cases.

Verification
REQ-033 SHALL cover: all 4 cores request continuously with fpu_gnt_i=1 -> grants in order 0,1,2,3,0 and fpu_ID_o 0,1,2,3,0.
REQ-034 SHALL cover: core 2 requests with fpu_gnt_i=0 for 3 cycles while core 1 raises its request -> core 2 stays selected, fpu_ID_o=2, and core 2 is granted when fpu_gnt_i=1.
REQ-035 SHALL cover: MAX_OUTSTANDING=4 with no responses -> after 4 handshakes outstanding_o=4 and fpu_req_o=0; one fpu_rvalid_i -> outstanding_o=3 and issue resumes.
REQ-036 SHALL cover: handshake and fpu_rvalid_i in the same cycle at count 2 -> outstanding_o stays 2.
REQ-037 SHALL cover: fpu_rvalid_i with fpu_rID_i=3 and data 0x3F800000 -> core_rvalid_o=4'b1000 and core_rdata_o=0x3F800000; with fpu_rID_i=5 -> core_rvalid_o=0.
REQ-038 SHALL cover: rst_n asserted at count 3 -> outstanding_o=0 and rr_ptr=0 immediately; the first grant after release goes to the lowest requesting core.
